mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the pipeline's memory-facing stages and the single byte-wide RAM port. It arbitrates instruction fetches from the icache against load/store requests from the MEM stage. Each granted access is serialised into 1, 2 or 4 byte transactions, and the controller returns assembled words with a one-cycle done pulse. While an instruction fetch is in flight it raises `icache_busy`, which makes the MEM stage stall and withdraw its request.

## Interface
Parameters:
- `ADDR_W`, 18: width of `ram_addr`; byte addresses are truncated to this width.
- `IO_HI`, 2'b11: value of `ram_addr[ADDR_W-1:ADDR_W-2]` that marks the I/O region (used only with the macro).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_enable`  in  1  data request valid (MEM stage).
- `mem_rw`  in  1  0 = read, 1 = write.
- `mem_type`  in  2  0 none, 1 byte, 2 half, 3 word.
- `mem_addr_i`  in  32  data byte address.
- `mem_wdata_i`  in  32  store data; low bytes used.
- `mem_data`  out  32  load result; zero-filled above the access size.
- `mem_data_enable`  out  1  one-cycle done pulse for a data access (load or store).
- `icache_busy`  out  1  high while an instruction fetch owns the RAM.
- `inst_req`  in  1  instruction fetch request.
- `inst_addr`  in  32  fetch byte address.
- `inst_data`  out  32  fetched word.
- `inst_data_enable`  out  1  one-cycle done pulse for a fetch.
- `ram_addr`  out  ADDR_W  RAM byte address.
- `ram_wr`  out  1  1 = write `ram_wdata` this cycle.
- `ram_wdata`  out  8  write byte.
- `ram_rdata`  in  8  read byte, valid one cycle after its address.
- `io_buffer_full`  in  1  I/O sink full; ignored without the macro.

## Operation
- States: IDLE, INST, DREAD, DWRITE, DONE.
- **IDLE arbitration:**
  - A valid data request (`mem_enable` high, `mem_type` ≠ 0) goes to DREAD or DWRITE.
  - Otherwise `inst_req` goes to INST.
  - Data wins when both requests arrive together.
  - `mem_enable` with `mem_type` = 0 is ignored.
- **On grant:** latch address, type/size N (1/2/4; INST always 4) and write data, and clear byte counter k.
- **INST / DREAD:**
  - Issue address base+k for k = 0..N-1, one per cycle.
  - Capture `ram_rdata` the cycle after each address into byte lane k (little-endian).
  - After the last byte is captured, go to DONE.
- **DWRITE:**
  - Drive `ram_wr` = 1, `ram_addr` = base+k and `ram_wdata` = wdata byte k, for k = 0..N-1.
  - Go to DONE after byte N-1.
- **DONE:**
  - Pulse exactly one of `mem_data_enable` / `inst_data_enable` for one cycle, with data held stable.
  - Return to IDLE. No new request is accepted in the DONE cycle.
- **Address arithmetic:** base+k is computed at 32 bits, then truncated to ADDR_W, so it wraps at 2^ADDR_W.
- **`icache_busy`:** high in INST and in the fetch's DONE cycle, low otherwise.
- **Write enable:** `ram_wr` is low in every state except active DWRITE byte cycles.
- **Reset values:** all outputs 0; state IDLE; k = 0. Reset mid-transaction aborts it: no done pulse, and partial RAM writes remain.

## Timing
- Request sampled at the end of cycle T0.
- **Reads of N bytes:**
  - Addresses are driven in T1..TN.
  - Bytes are captured at the ends of T2..T(N+1).
  - Done pulse in T(N+2): LW/fetch → T6, LH → T4, LB → T3.
- **Writes of N bytes:** bytes in T1..TN; done pulse in T(N+1) (SW → T5, SB → T2).
- Back-to-back accesses: the next grant is sampled in the cycle after the DONE cycle, so it can be granted no earlier than the cycle after DONE.
- `mem_data` / `inst_data` keep their last value until the next capture of that kind.

## Configuration
- **`MEM_CTRL_IO_STALL_EN` defined:**
  - In DWRITE, a byte whose truncated address has top two bits == IO_HI is not issued while `io_buffer_full` = 1.
  - While held, `ram_wr` = 0, k holds, and the done pulse is delayed by the number of held cycles.
- **Undefined:** `io_buffer_full` is ignored and write timing is always as in Timing.

## Test plan
- LW addr 0x100, RAM bytes 11 22 33 44 → `mem_data` = 0x44332211, pulse in T6, `icache_busy` = 0 throughout.
- SH addr 0x2FF, wdata 0xDEADBEEF → `ram_wr` writes EF@0x2FF then BE@0x300, pulse in T3, RAM otherwise unchanged.
- `inst_req` and LB request in the same IDLE cycle → LB served first (pulse T3). Fetch granted in the cycle after the LB's DONE, with `icache_busy` high through the fetch's DONE cycle.
- Fetch at 0x3FFFE with ADDR_W = 18 → addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001 (wrap).
- `rst` asserted in the second cycle of an SW → `ram_wr` 0 the next cycle, no pulse, state IDLE, all outputs 0.
- Macro on: SB to 0x30000 with `io_buffer_full` high for 3 cycles → write issued in T4, pulse in T5. Macro off → write in T1, pulse T2.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache fetches against MEM-stage loads/stores onto a
// single byte-wide RAM port, serialising each access into 1/2/4 byte cycles.
// Optional build macro: MEM_CTRL_IO_STALL_EN holds I/O-region write bytes
// while io_buffer_full is high.
module mem_ctrl #(
   parameter int         ADDR_W = 18,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_enable,
   input  logic              mem_rw,
   input  logic [1:0]        mem_type,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_data,
   output logic              mem_data_enable,
   output logic              icache_busy,
   input  logic              inst_req,
   input  logic [31:0]       inst_addr,
   output logic [31:0]       inst_data,
   output logic              inst_data_enable,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              io_buffer_full
);

   typedef enum logic [2:0] {S_IDLE, S_INST, S_DREAD, S_DWRITE, S_DONE} state_t;

   state_t            state_q;
   logic [31:0]       base_q, wdata_q, rbuf_q;
   logic [2:0]        n_q, k_q;
   logic              cap_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_wr_q;
   logic [7:0]        ram_wdata_q;
   logic [31:0]       mem_data_q, inst_data_q;
   logic              mem_de_q, inst_de_q, busy_q;

   logic [2:0]        k_nx;
   logic [1:0]        lane;
   logic [ADDR_W-1:0] addr_nx;
   logic [31:0]       rbuf_d;
   logic              hold;

   function automatic logic [2:0] size_of(input logic [1:0] t);
      case (t)
         2'd1:    size_of = 3'd1;
         2'd2:    size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   // Next byte index and its RAM address (32-bit add, then wrap to ADDR_W)
   assign k_nx    = k_q + 3'd1;
   assign addr_nx = ADDR_W'(base_q + {29'd0, k_nx});
   // Byte on the bus last cycle was index k-1; that is the lane captured now
   assign lane    = k_q[1:0] - 2'd1;

   // Read buffer with the byte arriving this cycle merged into its lane
   always_comb begin
      rbuf_d = rbuf_q;
      rbuf_d[{lane, 3'b000} +: 8] = ram_rdata;
   end

`ifdef MEM_CTRL_IO_STALL_EN
   // A write byte aimed at the I/O region waits while the sink is full
   assign hold = (state_q == S_DWRITE) && (ram_addr_q[ADDR_W-1 -: 2] == IO_HI) && io_buffer_full;
`else
   assign hold = 1'b0;
   wire unused_io = &{1'b0, io_buffer_full, IO_HI};
`endif

   assign ram_wr           = ram_wr_q & ~hold;
   assign ram_addr         = ram_addr_q;
   assign ram_wdata        = ram_wdata_q;
   assign mem_data         = mem_data_q;
   assign inst_data        = inst_data_q;
   assign mem_data_enable  = mem_de_q;
   assign inst_data_enable = inst_de_q;
   assign icache_busy      = busy_q;

   // Main FSM: arbitration, byte serialisation, result assembly and done pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         n_q         <= '0;
         k_q         <= '0;
         cap_q       <= 1'b0;
         ram_addr_q  <= '0;
         ram_wr_q    <= 1'b0;
         ram_wdata_q <= '0;
         mem_data_q  <= '0;
         inst_data_q <= '0;
         mem_de_q    <= 1'b0;
         inst_de_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mem_de_q  <= 1'b0;
         inst_de_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               k_q    <= '0;
               cap_q  <= 1'b0;
               rbuf_q <= '0;
               // Data beats fetch when both arrive; mem_type 0 is not a request
               if (mem_enable && mem_type != 2'd0) begin
                  base_q     <= mem_addr_i;
                  wdata_q    <= mem_wdata_i;
                  n_q        <= size_of(mem_type);
                  ram_addr_q <= mem_addr_i[ADDR_W-1:0];
                  if (mem_rw) begin
                     state_q     <= S_DWRITE;
                     ram_wr_q    <= 1'b1;
                     ram_wdata_q <= mem_wdata_i[7:0];
                  end else begin
                     state_q <= S_DREAD;
                  end
               end else if (inst_req) begin
                  base_q     <= inst_addr;
                  n_q        <= 3'd4;
                  ram_addr_q <= inst_addr[ADDR_W-1:0];
                  busy_q     <= 1'b1;
                  state_q    <= S_INST;
               end
            end
            S_INST, S_DREAD: begin
               if (cap_q) rbuf_q <= rbuf_d;
               if (cap_q && k_q == n_q) begin
                  state_q <= S_DONE;
                  if (state_q == S_INST) begin
                     inst_data_q <= rbuf_d;
                     inst_de_q   <= 1'b1;
                  end else begin
                     mem_data_q <= rbuf_d;
                     mem_de_q   <= 1'b1;
                  end
               end else begin
                  k_q   <= k_nx;
                  cap_q <= 1'b1;
                  // Past the last byte the address bus simply holds
                  if (k_nx < n_q) ram_addr_q <= addr_nx;
               end
            end
            S_DWRITE: begin
               if (!hold) begin
                  if (k_nx == n_q) begin
                     state_q  <= S_DONE;
                     ram_wr_q <= 1'b0;
                     mem_de_q <= 1'b1;
                  end else begin
                     k_q         <= k_nx;
                     ram_addr_q  <= addr_nx;
                     ram_wdata_q <= wdata_q[{k_nx[1:0], 3'b000} +: 8];
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done pulses,
// a negedge monitor pops and checks them; a byte RAM model logs writes.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_enable, mem_rw;
   logic [1:0]  mem_type;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_data;
   logic        mem_data_enable, icache_busy;
   logic        inst_req;
   logic [31:0] inst_addr, inst_data;
   logic        inst_data_enable;
   logic [17:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        io_buffer_full;

   mem_ctrl #(.ADDR_W(18), .IO_HI(2'b11)) dut (
      .clk(clk), .rst(rst),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_type(mem_type),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_data(mem_data), .mem_data_enable(mem_data_enable),
      .icache_busy(icache_busy),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_data(inst_data), .inst_data_enable(inst_data_enable),
      .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .io_buffer_full(io_buffer_full)
   );

   always #5 clk = ~clk;

   typedef struct { bit inst; logic [31:0] d; int c; } exp_t;
   typedef struct { logic [17:0] a; logic [7:0] d; int c; } wr_t;

   exp_t q[$];
   wr_t  wlog[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   c0;
   logic [7:0] ram [0:(1<<18)-1];

   always @(posedge clk) cyc <= cyc + 1;

   // Byte RAM: read data valid the cycle after its address
   always @(posedge clk) begin
      ram_rdata <= ram[ram_addr];
      if (ram_wr) begin
         ram[ram_addr] <= ram_wdata;
         wlog.push_back('{ram_addr, ram_wdata, cyc});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && (mem_data_enable || inst_data_enable)) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pulse mem=%b inst=%b cyc=%0d", mem_data_enable, inst_data_enable, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_kind", {31'd0, inst_data_enable}, {31'd0, mon_e.inst});
            chk("one_pulse", {31'd0, mem_data_enable & inst_data_enable}, 32'd0);
            chk("pulse_cyc", cyc, mon_e.c);
            chk("pulse_data", mon_e.inst ? inst_data : mem_data, mon_e.d);
         end
      end
   end

   task automatic issue(input bit rw, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] expd, input int lat);
      wlog.delete();
      mem_enable = 1'b1; mem_rw = rw; mem_type = t; mem_addr_i = a; mem_wdata_i = wd;
      c0 = cyc;
      q.push_back('{1'b0, expd, c0 + lat});
      @(posedge clk); #1;
      mem_enable = 1'b0; mem_type = 2'd0; mem_rw = 1'b0;
   endtask

   task automatic wait_done(input int lim, input bit busy_low);
      int n = 0;
      while (q.size() != 0 && n < lim) begin
         if (busy_low) chk("busy_low", {31'd0, icache_busy}, 32'd0);
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic chk_w(input int idx, input logic [17:0] a, input logic [7:0] d, input int c);
      if (idx >= wlog.size()) begin
         checks++;
         failures++;
         $display("FAIL write_missing idx=%0d actual_count=%0d expected_addr=%h", idx, wlog.size(), a);
      end else begin
         chk("write_addr", {14'd0, wlog[idx].a}, {14'd0, a});
         chk("write_data", {24'd0, wlog[idx].d}, {24'd0, d});
         chk("write_cyc", wlog[idx].c, c);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [17:0] wrap_a [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
   logic [7:0]  sw_b   [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

   initial begin
      rst = 1'b1; mem_enable = 1'b0; mem_rw = 1'b0; mem_type = 2'd0;
      mem_addr_i = '0; mem_wdata_i = '0; inst_req = 1'b0; inst_addr = '0;
      io_buffer_full = 1'b0;
      for (int i = 0; i < (1 << 18); i++) ram[i] <= 8'h00;
      ram[18'h100] <= 8'h11; ram[18'h101] <= 8'h22; ram[18'h102] <= 8'h33; ram[18'h103] <= 8'h44;
      ram[18'h200] <= 8'hAA; ram[18'h201] <= 8'hBB;
      ram[18'h3FFFE] <= 8'hA1; ram[18'h3FFFF] <= 8'hB2; ram[18'h00000] <= 8'hC3; ram[18'h00001] <= 8'hD4;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_mem_data", mem_data, 0);
      chk("rst_mem_de", {31'd0, mem_data_enable}, 0);
      chk("rst_busy", {31'd0, icache_busy}, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_de", {31'd0, inst_data_enable}, 0);
      chk("rst_ram_addr", {14'd0, ram_addr}, 0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 0);
      chk("rst_ram_wdata", {24'd0, ram_wdata}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // LW 0x100 -> 0x44332211 in T6, busy low throughout
      issue(1'b0, 2'd3, 32'h100, 32'h0, 32'h44332211, 6);
      wait_done(20, 1'b1);
      // LH zero-fills above the halfword
      issue(1'b0, 2'd2, 32'h200, 32'h0, 32'h0000BBAA, 4);
      wait_done(20, 1'b1);
      // LB
      issue(1'b0, 2'd1, 32'h101, 32'h0, 32'h00000022, 3);
      wait_done(20, 1'b1);

      // SH across 0x2FF/0x300; mem_data keeps the last load
      issue(1'b1, 2'd2, 32'h2FF, 32'hDEADBEEF, 32'h00000022, 3);
      wait_done(20, 1'b1);
      chk_w(0, 18'h2FF, 8'hEF, c0 + 1);
      chk_w(1, 18'h300, 8'hBE, c0 + 2);
      chk("sh_write_count", wlog.size(), 2);
      chk("sh_below", {24'd0, ram[18'h2FE]}, 0);
      chk("sh_above", {24'd0, ram[18'h301]}, 0);

      // SW then read back
      issue(1'b1, 2'd3, 32'h400, 32'h12345678, 32'h00000022, 5);
      wait_done(20, 1'b1);
      for (int i = 0; i < 4; i++) chk_w(i, 18'h400 + 18'(i), sw_b[i], c0 + 1 + i);
      chk("sw_write_count", wlog.size(), 4);
      issue(1'b0, 2'd3, 32'h400, 32'h0, 32'h12345678, 6);
      wait_done(20, 1'b1);

      // mem_type 0 is not a request: no write, no pulse
      wlog.delete();
      mem_enable = 1'b1; mem_rw = 1'b1; mem_type = 2'd0; mem_addr_i = 32'h600; mem_wdata_i = 32'hFF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("type0_no_wr", {31'd0, ram_wr}, 0);
      end
      mem_enable = 1'b0; mem_rw = 1'b0;
      @(posedge clk); #1;
      chk("type0_no_log", wlog.size(), 0);

      // Simultaneous LB and fetch: LB first, fetch granted after LB's DONE
      mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd1; mem_addr_i = 32'h100;
      inst_req = 1'b1; inst_addr = 32'h100;
      c0 = cyc;
      q.push_back('{1'b0, 32'h00000011, c0 + 3});
      q.push_back('{1'b1, 32'h44332211, c0 + 10});
      @(posedge clk); #1;
      mem_enable = 1'b0; mem_type = 2'd0;
      for (int i = 1; i <= 12; i++) begin
         chk("arb_busy", {31'd0, icache_busy}, {31'd0, (i >= 5 && i <= 10)});
         if (i == 5) inst_req = 1'b0;
         @(posedge clk); #1;
      end
      chk("arb_q_empty", q.size(), 0);
      q.delete();

      // Fetch wraps at 2^18
      inst_req = 1'b1; inst_addr = 32'h3FFFE;
      c0 = cyc;
      q.push_back('{1'b1, 32'hD4C3B2A1, c0 + 6});
      @(posedge clk); #1;
      inst_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_addr", {14'd0, ram_addr}, {14'd0, wrap_a[i]});
         chk("wrap_busy", {31'd0, icache_busy}, 1);
         @(posedge clk); #1;
      end
      wait_done(20, 1'b0);

      // Reset in the second cycle of a SW aborts it
      wlog.delete();
      mem_enable = 1'b1; mem_rw = 1'b1; mem_type = 2'd3; mem_addr_i = 32'h500; mem_wdata_i = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_enable = 1'b0; mem_type = 2'd0; mem_rw = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_wr", {31'd0, ram_wr}, 0);
      chk("rst_mid_mem_data", mem_data, 0);
      chk("rst_mid_inst_data", inst_data, 0);
      chk("rst_mid_addr", {14'd0, ram_addr}, 0);
      chk("rst_mid_busy", {31'd0, icache_busy}, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_mid_byte0", {24'd0, ram[18'h500]}, 32'h0D);
      chk("rst_mid_byte2", {24'd0, ram[18'h502]}, 0);
      chk("rst_mid_byte3", {24'd0, ram[18'h503]}, 0);
      // Controller is idle again: a fresh LB runs with normal latency
      issue(1'b0, 2'd1, 32'h101, 32'h0, 32'h00000022, 3);
      wait_done(20, 1'b1);

      // SB into the I/O region with the sink full for three cycles
      io_buffer_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
      issue(1'b1, 2'd1, 32'h30000, 32'h0000005A, 32'h00000022, 5);
`else
      issue(1'b1, 2'd1, 32'h30000, 32'h0000005A, 32'h00000022, 2);
`endif
      repeat (3) begin
         @(posedge clk); #1;
      end
      io_buffer_full = 1'b0;
      wait_done(20, 1'b0);
`ifdef MEM_CTRL_IO_STALL_EN
      chk_w(0, 18'h30000, 8'h5A, c0 + 4);
`else
      chk_w(0, 18'h30000, 8'h5A, c0 + 1);
`endif
      chk("io_write_count", wlog.size(), 1);

      repeat (3) @(posedge clk);
      #1;
      chk("final_q_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
